// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that frames one requester's payload as SOF, header, payload, XOR checksum
// and pushes it byte-by-byte into a UART TX FIFO, stalling while the FIFO is full.
//
// state | meaning
// IDLE  | no frame in progress; scan req from rr pointer and grant the first hit
// SOF   | writing SOF_BYTE
// HDR   | writing {id, len}; loads remaining count
// PAY   | writing granted requester's payload bytes, acking each one
// CSUM  | writing accumulated XOR checksum, then release grant and rotate pointer
module uart_tx_arbiter #(
   parameter int          NREQ     = 4,
   parameter logic [7:0]  SOF_BYTE = 8'hA5
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [NREQ-1:0]     req,
   input  logic [4*NREQ-1:0]   req_len,
   input  logic [8*NREQ-1:0]   req_data,
   output logic [NREQ-1:0]     data_ack,
   output logic [NREQ-1:0]     grant,
   output logic [NREQ-1:0]     frame_done,
   output logic                busy,
   output logic [7:0]          w_data,
   output logic                wr_uart,
   input  logic                tx_full
);

   typedef enum logic [2:0] {IDLE, SOF, HDR, PAY, CSUM} state_t;

   localparam logic [3:0] LAST_ID = 4'(NREQ - 1);

   state_t            state_q;
   logic [3:0]        id_q;
   logic [3:0]        len_q;
   logic [3:0]        cnt_q;
   logic [3:0]        ptr_q;
   logic [7:0]        csum_q;
   logic [NREQ-1:0]   grant_q;

   logic [15:0]       req_ext;
   logic [63:0]       len_ext;
   logic [127:0]      data_ext;
   logic [4:0]        scan;
   logic              sel_vld;
   logic [3:0]        sel_id;
   logic [7:0]        hdr_byte;
   logic [7:0]        pay_byte;

   // Zero-extended copies let every NREQ in 2..16 be indexed with a plain 4-bit id.
   assign req_ext  = 16'(req);
   assign len_ext  = 64'(req_len);
   assign data_ext = 128'(req_data);
   assign hdr_byte = {id_q, len_q};
   assign pay_byte = data_ext[{id_q, 3'b000} +: 8];

   always_comb begin
      sel_vld = 1'b0;
      sel_id  = '0;
      scan    = '0;
      for (int k = 0; k < NREQ; k++) begin
         scan = {1'b0, ptr_q} + 5'(k);
         if (scan >= 5'(NREQ)) scan = scan - 5'(NREQ);
         if (!sel_vld && req_ext[scan[3:0]]) begin
            sel_vld = 1'b1;
            sel_id  = scan[3:0];
         end
      end
   end

   always_comb begin
      wr_uart = (state_q != IDLE) && !tx_full;
      busy    = (state_q != IDLE);
      case (state_q)
         SOF:     w_data = SOF_BYTE;
         HDR:     w_data = hdr_byte;
         PAY:     w_data = pay_byte;
         CSUM:    w_data = csum_q;
         default: w_data = 8'h00;
      endcase
   end

   // grant_q is one-hot of id_q, so masking it yields the per-requester strobes.
   assign grant      = grant_q;
   assign data_ack   = grant_q & {NREQ{wr_uart && (state_q == PAY)}};
   assign frame_done = grant_q & {NREQ{wr_uart && (state_q == CSUM)}};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         id_q    <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
         ptr_q   <= '0;
         csum_q  <= '0;
         grant_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (sel_vld) begin
                  id_q    <= sel_id;
                  len_q   <= len_ext[{sel_id, 2'b00} +: 4];
                  csum_q  <= '0;
                  grant_q <= NREQ'(16'h0001 << sel_id);
                  state_q <= SOF;
               end
            end
            SOF: begin
               if (wr_uart) state_q <= HDR;
            end
            HDR: begin
               if (wr_uart) begin
                  csum_q  <= csum_q ^ hdr_byte;
                  cnt_q   <= len_q;
                  state_q <= (len_q != 4'd0) ? PAY : CSUM;
               end
            end
            PAY: begin
               if (wr_uart) begin
                  csum_q <= csum_q ^ pay_byte;
                  cnt_q  <= cnt_q - 4'd1;
                  if (cnt_q == 4'd1) state_q <= CSUM;
               end
            end
            CSUM: begin
               if (wr_uart) begin
                  grant_q <= '0;
                  ptr_q   <= (id_q == LAST_ID) ? 4'd0 : id_q + 4'd1;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: framing, round-robin order, backpressure,
// zero-length frames, mid-frame reset and request drop.
module tb_uart_tx_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [3:0]  req;
   logic [15:0] req_len;
   logic [31:0] req_data;
   logic [3:0]  data_ack;
   logic [3:0]  grant;
   logic [3:0]  frame_done;
   logic        busy;
   logic [7:0]  w_data;
   logic        wr_uart;
   logic        tx_full;

   int checks   = 0;
   int failures = 0;

   logic [7:0] pay [4][16];
   logic [7:0] expb [20];
   logic [7:0] got [20];

   uart_tx_arbiter #(.NREQ(4), .SOF_BYTE(8'hA5)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .req        (req),
      .req_len    (req_len),
      .req_data   (req_data),
      .data_ack   (data_ack),
      .grant      (grant),
      .frame_done (frame_done),
      .busy       (busy),
      .w_data     (w_data),
      .wr_uart    (wr_uart),
      .tx_full    (tx_full)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Runs from an input-drive point until the frame's checksum is written,
   // then compares the captured byte stream against a hand-built frame.
   task automatic frame(input string tag, input int id, input int len,
                        input int stall_at, input int exp_idle);
      logic [7:0] cs;
      int gotn, acks, dones, idle, stall, idx;
      bit finished;
      expb[0] = 8'hA5;
      expb[1] = {4'(id), 4'(len)};
      cs = expb[1];
      for (int k = 0; k < len; k++) begin
         expb[2+k] = pay[id][k];
         cs = cs ^ pay[id][k];
      end
      expb[len+2] = cs;
      gotn = 0; acks = 0; dones = 0; idle = 0; stall = 0; idx = 0; finished = 0;
      for (int cyc = 0; cyc < 200 && !finished; cyc++) begin
         req_data[8*id +: 8] = pay[id][idx < 16 ? idx : 15];
         tx_full = (gotn == stall_at) && (stall < 5);
         #1;
         if (tx_full && busy) begin
            stall++;
            chk({tag, "_stall_wr"}, 32'(wr_uart), 32'd0);
            chk({tag, "_stall_ack"}, 32'(data_ack), 32'd0);
            chk({tag, "_stall_wdata"}, 32'(w_data), 32'(expb[stall_at]));
         end
         if (!busy) idle++;
         if (wr_uart) begin
            if (gotn == 0) chk({tag, "_grant"}, 32'(grant), 32'd1 << id);
            if (gotn < 20) got[gotn] = w_data;
            gotn++;
         end
         if (data_ack != 4'd0) begin
            chk({tag, "_ack"}, 32'(data_ack), 32'd1 << id);
            acks++;
            idx++;
         end
         if (frame_done != 4'd0) begin
            chk({tag, "_done"}, 32'(frame_done), 32'd1 << id);
            dones++;
            finished = 1;
         end
         tick();
      end
      tx_full = 1'b0;
      chk({tag, "_timeout"}, 32'(finished), 32'd1);
      chk({tag, "_nbytes"}, 32'(gotn), 32'(len + 3));
      for (int k = 0; k < len + 3 && k < gotn && k < 20; k++)
         chk($sformatf("%s_byte%0d", tag, k), 32'(got[k]), 32'(expb[k]));
      chk({tag, "_nacks"}, 32'(acks), 32'(len));
      chk({tag, "_ndone"}, 32'(dones), 32'd1);
      if (exp_idle >= 0) chk({tag, "_idle"}, 32'(idle), 32'(exp_idle));
      if (stall_at >= 0) chk({tag, "_nstall"}, 32'(stall), 32'd5);
   endtask

   initial begin
      for (int i = 0; i < 4; i++)
         for (int k = 0; k < 16; k++)
            pay[i][k] = 8'h00;
      pay[1][0] = 8'h11; pay[1][1] = 8'h22; pay[1][2] = 8'h33;
      pay[3][0] = 8'h01; pay[3][1] = 8'h02; pay[3][2] = 8'h04; pay[3][3] = 8'h08;
      pay[0][0] = 8'hAA; pay[0][1] = 8'hBB;

      reset_n = 1'b0; req = '0; req_len = '0; req_data = '0; tx_full = 1'b0;
      tick(); tick();
      #1;
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_wr", 32'(wr_uart), 32'd0);
      chk("rst_wdata", 32'(w_data), 32'd0);
      chk("rst_ack", 32'(data_ack), 32'd0);
      chk("rst_done", 32'(frame_done), 32'd0);
      tick();
      reset_n = 1'b1;
      tick();

      // Single frame: A5,13,11,22,33,13
      req = 4'b0010; req_len[7:4] = 4'd3;
      frame("single", 1, 3, -1, 1);
      req = '0;
      #1;
      chk("single_busy_after", 32'(busy), 32'd0);
      chk("single_grant_after", 32'(grant), 32'd0);
      tick();

      // Zero length: A5,20,20
      req = 4'b0100; req_len[11:8] = 4'd0;
      frame("zero", 2, 0, -1, 1);
      req = '0;
      tick();

      // Backpressure on payload byte 2: A5,34,01,02,04,08,3B
      req = 4'b1000; req_len[15:12] = 4'd4;
      frame("bp", 3, 4, 3, 1);
      req = '0;
      tick();

      // Request dropped right after grant: A5,02,AA,BB,13
      req = 4'b0001; req_len[3:0] = 4'd2;
      tick();
      req = '0;
      frame("drop", 0, 2, -1, 0);
      tick();

      // Reset once HDR has been written
      req = 4'b0010; req_len[7:4] = 4'd3;
      tick();
      req = '0;
      tick(); tick();
      #1;
      chk("mid_busy_before", 32'(busy), 32'd1);
      reset_n = 1'b0;
      #1;
      chk("mid_grant", 32'(grant), 32'd0);
      chk("mid_busy", 32'(busy), 32'd0);
      chk("mid_wr", 32'(wr_uart), 32'd0);
      chk("mid_wdata", 32'(w_data), 32'd0);
      chk("mid_ack", 32'(data_ack), 32'd0);
      tick(); tick();
      reset_n = 1'b1;
      req = 4'b1000; req_len[15:12] = 4'd0;
      frame("postrst", 3, 0, -1, 1);

      // Contention with all requesters held, pointer starts at 0
      pay[0][0] = 8'hC0; pay[1][0] = 8'hC1; pay[2][0] = 8'hC2; pay[3][0] = 8'hC3;
      req = 4'b1111; req_len = 16'h1111;
      frame("rr0", 0, 1, -1, 1);
      frame("rr1", 1, 1, -1, 1);
      frame("rr2", 2, 1, -1, 1);
      frame("rr3", 3, 1, -1, 1);
      frame("rr0b", 0, 1, -1, 1);
      req = '0;
      tick(); tick();
      #1;
      chk("end_busy", 32'(busy), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
